// File: rtl/key_press_classifier.sv
// Four-key front end: 2-flop sync, per-key debounce, and a short/long press classifier
// that emits one-cycle pulses per key.
module key_press_classifier #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 40000000
) (
   input  logic       CLOCK_50,
   input  logic       rst,
   input  logic       en,
   input  logic [4:1] keys,
   output logic [4:1] key_down,
   output logic [4:1] short_press,
   output logic [4:1] long_press
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   // hcnt starts at 0 on the first held sample, so L-2 is the last value before "long".
   localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_CYCLES - 2);

   typedef enum logic [1:0] {IDLE, HELD, LONG} state_e;

   logic [4:1] sync1_q, sync2_q;

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= keys;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 1; i <= 4; i++) begin : g_ch
      logic [DW-1:0] dcnt_q, dcnt_d;
      logic [HW-1:0] hcnt_q, hcnt_d;
      logic          kd_q, kd_d;
      logic          sp_q, sp_d;
      logic          lp_q, lp_d;
      state_e        state_q, state_d;

      always_ff @(posedge CLOCK_50) begin
         if (rst) begin
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            kd_q    <= 1'b0;
            sp_q    <= 1'b0;
            lp_q    <= 1'b0;
            state_q <= IDLE;
         end else begin
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            kd_q    <= kd_d;
            sp_q    <= sp_d;
            lp_q    <= lp_d;
            state_q <= state_d;
         end
      end

      // Debounce: accept a level change only after DEBOUNCE_CYCLES differing samples.
      always_comb begin
         dcnt_d = '0;
         kd_d   = kd_q;
         if (!en) begin
            kd_d = 1'b0;
         end else if (!sync2_q[i] != kd_q) begin
            if (dcnt_q == DCNT_LAST) begin
               kd_d = !kd_q;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
      end

      always_comb begin
         state_d = state_q;
         hcnt_d  = hcnt_q;
         sp_d    = 1'b0;
         lp_d    = 1'b0;
         case (state_q)
            IDLE: begin
               if (kd_q) begin
                  state_d = HELD;
                  hcnt_d  = '0;
               end
            end
            HELD: begin
               if (!kd_q) begin
                  state_d = IDLE;
                  sp_d    = 1'b1;
               end else if (hcnt_q == HCNT_LAST) begin
                  state_d = LONG;
                  lp_d    = 1'b1;
                  hcnt_d  = hcnt_q + HW'(1);
               end else begin
                  hcnt_d  = hcnt_q + HW'(1);
               end
            end
            LONG: begin
               if (!kd_q) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
         if (!en) begin
            state_d = IDLE;
            hcnt_d  = '0;
            sp_d    = 1'b0;
            lp_d    = 1'b0;
         end
      end

      assign key_down[i]    = kd_q;
      assign short_press[i] = sp_q;
      assign long_press[i]  = lp_q;
   end

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomized and directed bench for key_press_classifier against a per-key
// sample-counting reference model.
module tb_key_press_classifier;

   localparam int D = 4;
   localparam int L = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [4:1] keys = 4'b1111;
   logic [4:1] key_down, short_press, long_press;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   key_press_classifier #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
      .CLOCK_50   (clk),
      .rst        (rst),
      .en         (en),
      .keys       (keys),
      .key_down   (key_down),
      .short_press(short_press),
      .long_press (long_press)
   );

   always #5 clk = ~clk;

   // Reference: raw samples pass two stages; run = consecutive samples disagreeing with
   // the debounced level; hold = consecutive debounced-high samples of the current press.
   logic       m_s1 [4:1] = '{1'b1, 1'b1, 1'b1, 1'b1};
   logic       m_s2 [4:1] = '{1'b1, 1'b1, 1'b1, 1'b1};
   int         m_run  [4:1] = '{0, 0, 0, 0};
   int         m_hold [4:1] = '{0, 0, 0, 0};
   logic [4:1] m_kd = '0, m_sp = '0, m_lp = '0;

   initial begin : model
      forever begin
         @(posedge clk);
         for (int i = 1; i <= 4; i++) begin
            logic pressed, old_kd;
            if (rst) begin
               m_s1[i] = 1'b1; m_s2[i] = 1'b1;
               m_run[i] = 0; m_hold[i] = 0;
               m_kd[i] = 1'b0; m_sp[i] = 1'b0; m_lp[i] = 1'b0;
            end else begin
               pressed = !m_s2[i];
               old_kd  = m_kd[i];
               m_s2[i] = m_s1[i];
               m_s1[i] = keys[i];
               m_sp[i] = 1'b0;
               m_lp[i] = 1'b0;
               if (!en) begin
                  m_run[i] = 0; m_hold[i] = 0; m_kd[i] = 1'b0;
               end else begin
                  if (old_kd) begin
                     m_hold[i] = m_hold[i] + 1;
                     if (m_hold[i] == L) m_lp[i] = 1'b1;
                  end else begin
                     if (m_hold[i] > 0 && m_hold[i] < L) m_sp[i] = 1'b1;
                     m_hold[i] = 0;
                  end
                  if (pressed != old_kd) begin
                     m_run[i] = m_run[i] + 1;
                     if (m_run[i] == D) begin
                        m_kd[i]  = !old_kd;
                        m_run[i] = 0;
                     end
                  end else begin
                     m_run[i] = 0;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [4:1] act, input logic [4:1] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("model_key_down", key_down, m_kd);
         check("model_short", short_press, m_sp);
         check("model_long", long_press, m_lp);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold keys in mask k low for n samples; pin key_down at edges 5/6 and pulses at edge c.
   task automatic run_press(input logic [4:1] k, input int n, input int c,
                            input logic [4:1] exp_s, input logic [4:1] exp_l);
      keys = ~k;
      for (int e = 1; e <= n + 30; e++) begin
         @(negedge clk);
         if (e == n) keys = 4'b1111;
         if (e == 5) check("lit_kd_before", key_down, 4'b0000);
         if (e == 6) check("lit_kd_rise", key_down, k);
         if (e == c) begin
            check("lit_short", short_press, exp_s);
            check("lit_long", long_press, exp_l);
         end
      end
   endtask

   int remain [4:1];

   initial begin
      @(negedge clk);
      chk_on = 1'b1;
      tick(2);
      rst = 1'b0;
      check("lit_reset_kd", key_down, 4'b0000);
      check("lit_reset_short", short_press, 4'b0000);
      check("lit_reset_long", long_press, 4'b0000);
      tick(3);

      run_press(4'b0001, 12, 19, 4'b0001, 4'b0000);
      run_press(4'b0001, 19, 26, 4'b0001, 4'b0000);
      run_press(4'b0001, 20, 26, 4'b0000, 4'b0001);
      run_press(4'b0001, 40, 26, 4'b0000, 4'b0001);
      run_press(4'b1100, 8, 15, 4'b1100, 4'b0000);

      // Bounce on key2, then a steady press
      for (int r = 0; r < 5; r++) begin
         keys[2] = 1'b0; tick(2);
         keys[2] = 1'b1; tick(1);
      end
      tick(10);
      keys[2] = 1'b0; tick(10);
      keys[2] = 1'b1; tick(15);

      // Key3 long while key4 is tapped
      keys[3] = 1'b0; tick(5);
      keys[4] = 1'b0; tick(8);
      keys[4] = 1'b1; tick(17);
      keys[3] = 1'b1; tick(15);

      // Reset mid-press
      keys[1] = 1'b0; tick(10);
      rst = 1'b1; tick(1);
      check("lit_rst_kd", key_down, 4'b0000);
      check("lit_rst_short", short_press, 4'b0000);
      check("lit_rst_long", long_press, 4'b0000);
      rst = 1'b0; tick(2);
      keys[1] = 1'b1; tick(15);

      // Enable dropped mid-press, restored with key still held
      keys[1] = 1'b0; tick(10);
      en = 1'b0; tick(1);
      check("lit_en_kd", key_down, 4'b0000);
      tick(2);
      en = 1'b1; tick(15);
      keys[1] = 1'b1; tick(15);

      // Randomized key activity with sporadic enable drops and resets
      for (int i = 1; i <= 4; i++) remain[i] = $urandom_range(1, 30);
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         for (int i = 1; i <= 4; i++) begin
            remain[i]--;
            if (remain[i] <= 0) begin
               keys[i]   = !keys[i];
               remain[i] = $urandom_range(1, 30);
            end
         end
         en  = ($urandom_range(0, 99) >= 2);
         rst = ($urandom_range(0, 999) < 5);
      end
      rst = 1'b0; en = 1'b1; keys = 4'b1111;
      tick(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
